// File: rtl/ram_fifo_ctrl.sv
// Push/pop FIFO controller that owns both ports of an external dual-port RAM.
// Port 1 writes at wr_ptr; port 2 reads at rd_ptr and the RAM's registered output is qualified by pop_valid.
module ram_fifo_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 3,
  parameter int AFULL_LEVEL = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow,
  output logic             ram_we1,
  output logic [DEPTH-1:0] ram_addr1,
  output logic [WIDTH-1:0] ram_data1,
  output logic             ram_we2,
  output logic [DEPTH-1:0] ram_addr2,
  input  logic [WIDTH-1:0] ram_out2
);

  localparam logic [DEPTH:0]   CAP_C   = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0]   AFULL_C = (DEPTH+1)'(AFULL_LEVEL);
  localparam logic [DEPTH:0]   ONE_C   = (DEPTH+1)'(1);
  localparam logic [DEPTH-1:0] ONE_P   = DEPTH'(1);

  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic [DEPTH:0]   count_q;
  logic [DEPTH:0]   count_nxt;
  logic             full_q;
  logic             empty_q;
  logic             afull_q;
  logic             pop_valid_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             push_acc;
  logic             pop_acc;

  // Acceptance uses the registered flags, so a push while full is dropped even if a pop frees space this cycle.
  assign push_acc = push & ~full_q;
  assign pop_acc  = pop & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_nxt = count_q + ONE_C;
      2'b01:   count_nxt = count_q - ONE_C;
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      afull_q     <= 1'b0;
      pop_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ONE_P;
      if (pop_acc)  rd_ptr <= rd_ptr + ONE_P;
      count_q     <= count_nxt;
      empty_q     <= (count_nxt == '0);
      full_q      <= (count_nxt == CAP_C);
      afull_q     <= (count_nxt >= AFULL_C);
      pop_valid_q <= pop_acc;
      if (push & full_q)  overflow_q  <= 1'b1;
      if (pop & empty_q)  underflow_q <= 1'b1;
    end
  end

  // A read in flight when reset arrives is discarded rather than presented.
  assign pop_valid   = pop_valid_q & ~reset;
  assign pop_data    = ram_out2;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = afull_q;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

  assign ram_we1   = push_acc & ~reset;
  assign ram_addr1 = wr_ptr;
  assign ram_data1 = push_data;
  assign ram_we2   = 1'b0;
  assign ram_addr2 = rd_ptr;

endmodule
